// File: rtl/seq_alu_wb.sv
// Multi-cycle add/sub/mul/div unit feeding the register-file writeback port.
// Add/sub finish in one cycle; mul/div iterate one bit per cycle for WIDTH cycles.
module seq_alu_wb #(
    parameter int unsigned WIDTH     = 16,
    parameter logic [3:0]  WB_OPCODE = 4'b0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       f0,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] inp1,
    input  logic [WIDTH-1:0] inp2,
    input  logic             cin,
    input  logic             bin,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             carry,
    output logic             dbz,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_wb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic [CW-1:0]    cnt_q;
    logic [3:0]       opc_q;
    logic             dbz_q;

    logic             accept;
    logic             last;
    logic             opc_hit;
    logic             acc_hit;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quo;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign last     = (cnt_q == LAST);
    assign opc_hit  = (opc_q == WB_OPCODE);
    assign acc_hit  = (opcode == WB_OPCODE);

    assign add_sum  = {1'b0, inp1} + {1'b0, inp2} + {{WIDTH{1'b0}}, cin};
    assign sub_diff = {1'b0, inp1} - {1'b0, inp2} - {{WIDTH{1'b0}}, bin};

    // Shift-add: hi_q:lo_q holds partial product above the unconsumed multiplier bits.
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring division: hi_q is the running remainder, lo_q shifts dividend out and quotient in.
    assign div_trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, opnd_q};
    assign div_rem   = div_trial[WIDTH] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]}
                                        : div_trial[WIDTH-1:0];
    assign div_quo   = {lo_q[WIDTH-2:0], ~div_trial[WIDTH]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            opc_q     <= '0;
            dbz_q     <= 1'b0;
            out       <= '0;
            out_hi    <= '0;
            carry     <= 1'b0;
            dbz       <= 1'b0;
            out_valid <= 1'b0;
            out_wb    <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        unique case (f0)
                            2'b00: begin
                                out       <= add_sum[WIDTH-1:0];
                                out_hi    <= '0;
                                carry     <= add_sum[WIDTH];
                                dbz       <= 1'b0;
                                out_valid <= 1'b1;
                                if (acc_hit) out_wb <= add_sum[WIDTH-1:0];
                            end
                            2'b01: begin
                                out       <= sub_diff[WIDTH-1:0];
                                out_hi    <= '0;
                                carry     <= sub_diff[WIDTH];
                                dbz       <= 1'b0;
                                out_valid <= 1'b1;
                                if (acc_hit) out_wb <= sub_diff[WIDTH-1:0];
                            end
                            2'b10: begin
                                state  <= MUL;
                                hi_q   <= '0;
                                lo_q   <= inp2;
                                opnd_q <= inp1;
                                cnt_q  <= '0;
                                opc_q  <= opcode;
                                dbz_q  <= 1'b0;
                            end
                            2'b11: begin
                                state  <= DIV;
                                hi_q   <= '0;
                                lo_q   <= inp1;
                                opnd_q <= inp2;
                                cnt_q  <= '0;
                                opc_q  <= opcode;
                                dbz_q  <= (inp2 == '0);
                            end
                        endcase
                    end
                end
                MUL: begin
                    hi_q  <= mul_hi;
                    lo_q  <= mul_lo;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        state     <= IDLE;
                        cnt_q     <= '0;
                        out       <= mul_lo;
                        out_hi    <= mul_hi;
                        carry     <= 1'b0;
                        dbz       <= 1'b0;
                        out_valid <= 1'b1;
                        if (opc_hit) out_wb <= mul_lo;
                    end
                end
                DIV: begin
                    hi_q  <= div_rem;
                    lo_q  <= div_quo;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        state     <= IDLE;
                        cnt_q     <= '0;
                        out       <= div_quo;
                        out_hi    <= div_rem;
                        carry     <= 1'b0;
                        dbz       <= dbz_q;
                        out_valid <= 1'b1;
                        if (opc_hit) out_wb <= div_quo;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_wb.sv
// Directed testbench for seq_alu_wb (WIDTH=16, WB_OPCODE=0001).
// Expected values are hand-computed constants.
module tb_seq_alu_wb;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   f0 = 2'b00;
    logic [3:0]   opcode = 4'b0000;
    logic [W-1:0] inp1 = '0;
    logic [W-1:0] inp2 = '0;
    logic         cin = 1'b0;
    logic         bin = 1'b0;
    logic [W-1:0] out;
    logic [W-1:0] out_hi;
    logic         carry;
    logic         dbz;
    logic         out_valid;
    logic [W-1:0] out_wb;

    int n_chk = 0;
    int n_pass = 0;
    int lat;
    logic seen;

    always #5 clk = ~clk;

    seq_alu_wb #(.WIDTH(W), .WB_OPCODE(4'b0001)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .f0(f0), .opcode(opcode),
        .inp1(inp1), .inp2(inp2),
        .cin(cin), .bin(bin),
        .out(out), .out_hi(out_hi),
        .carry(carry), .dbz(dbz),
        .out_valid(out_valid), .out_wb(out_wb)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Issue one op and wait for its out_valid; lat counts edges from accept.
    task automatic run_op(input logic [1:0] f, input logic [3:0] opc,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic bw, output int l);
        @(negedge clk);
        f0 = f; opcode = opc; inp1 = a; inp2 = b; cin = c; bin = bw;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (f[1]) chk("busy_ready", in_ready, 0);
        l = 1;
        while (!out_valid && l < 64) begin
            @(posedge clk);
            #1 l++;
        end
    endtask

    initial begin
        #1;
        chk("rst_out", out, 0);
        chk("rst_hi", out_hi, 0);
        chk("rst_carry", carry, 0);
        chk("rst_dbz", dbz, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_wb", out_wb, 0);
        #22 rst_n = 1'b1;
        chk("rst_ready", in_ready, 1);

        run_op(2'b00, 4'b0001, 16'd120, 16'd10, 1'b0, 1'b0, lat);
        chk("add_lat", lat, 1);
        chk("add_out", out, 130);
        chk("add_carry", carry, 0);
        chk("add_hi", out_hi, 0);
        chk("add_wb", out_wb, 130);
        @(posedge clk); #1;
        chk("pulse_low", out_valid, 0);
        chk("hold_out", out, 130);

        run_op(2'b00, 4'b0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, lat);
        chk("addc_out", out, 0);
        chk("addc_carry", carry, 1);

        run_op(2'b01, 4'b0001, 16'd120, 16'd10, 1'b0, 1'b0, lat);
        chk("sub_lat", lat, 1);
        chk("sub_out", out, 110);
        chk("sub_carry", carry, 0);

        run_op(2'b01, 4'b0001, 16'd5, 16'd7, 1'b0, 1'b1, lat);
        chk("subb_out", out, 16'hFFFD);
        chk("subb_carry", carry, 1);

        run_op(2'b10, 4'b0001, 16'd120, 16'd10, 1'b0, 1'b0, lat);
        chk("mul_lat", lat, 17);
        chk("mul_out", out, 1200);
        chk("mul_hi", out_hi, 0);
        chk("mul_ready", in_ready, 1);
        chk("mul_wb", out_wb, 1200);

        run_op(2'b10, 4'b0001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, lat);
        chk("mulmax_out", out, 16'h0001);
        chk("mulmax_hi", out_hi, 16'hFFFE);

        run_op(2'b11, 4'b0001, 16'd120, 16'd10, 1'b0, 1'b0, lat);
        chk("div_lat", lat, 17);
        chk("div_out", out, 12);
        chk("div_hi", out_hi, 0);
        chk("div_dbz", dbz, 0);

        run_op(2'b11, 4'b0001, 16'd7, 16'd9, 1'b0, 1'b0, lat);
        chk("divs_out", out, 0);
        chk("divs_hi", out_hi, 7);

        run_op(2'b11, 4'b0001, 16'd120, 16'd0, 1'b0, 1'b0, lat);
        chk("dbz_lat", lat, 17);
        chk("dbz_out", out, 16'hFFFF);
        chk("dbz_hi", out_hi, 120);
        chk("dbz_flag", dbz, 1);
        chk("dbz_wb", out_wb, 16'hFFFF);

        run_op(2'b00, 4'b0010, 16'd3, 16'd4, 1'b0, 1'b0, lat);
        chk("nowb_out", out, 7);
        chk("nowb_dbz", dbz, 0);
        chk("nowb_wb", out_wb, 16'hFFFF);

        run_op(2'b10, 4'b0010, 16'd3, 16'd5, 1'b0, 1'b0, lat);
        chk("nowbm_out", out, 15);
        chk("nowbm_wb", out_wb, 16'hFFFF);

        // Held request while busy is taken in the result cycle.
        @(negedge clk);
        f0 = 2'b10; opcode = 4'b0001; inp1 = 16'd2; inp2 = 16'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1 f0 = 2'b00; inp1 = 16'd9; inp2 = 16'd1; cin = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("held_lat", lat, 17);
        chk("held_mul", out, 6);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("held_valid", out_valid, 1);
        chk("held_add", out, 10);

        // Three back-to-back adds.
        @(negedge clk);
        f0 = 2'b00; opcode = 4'b0001; inp1 = 16'd1; inp2 = 16'd1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 chk("b2b1_v", out_valid, 1);
        chk("b2b1_o", out, 2);
        inp1 = 16'd2;
        @(posedge clk);
        #1 chk("b2b2_v", out_valid, 1);
        chk("b2b2_o", out, 3);
        inp1 = 16'd40;
        @(posedge clk);
        #1 chk("b2b3_v", out_valid, 1);
        chk("b2b3_o", out, 41);
        in_valid = 1'b0;
        @(posedge clk);
        #1 chk("b2b_end", out_valid, 0);

        // Reset during a multiply.
        @(negedge clk);
        f0 = 2'b10; opcode = 4'b0001; inp1 = 16'd100; inp2 = 16'd100;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_out", out, 0);
        chk("mr_wb", out_wb, 0);
        chk("mr_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        chk("mr_novalid", seen, 0);
        run_op(2'b00, 4'b0001, 16'd2, 16'd3, 1'b0, 1'b0, lat);
        chk("mr_lat", lat, 1);
        chk("mr_add", out, 5);
        chk("mr_addwb", out_wb, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
